decode_queue_stage: RTL and testbench
=====================================

// Module: decode_queue_stage
// PURPOSE
//  Registered RV32IM decode stage between fetch and execute. Accepts instructions via valid/ready, decodes each to an
//  rv32i_control_word plus register indices, and buffers results in a DEPTH-entry FIFO. Adds illegal-op flagging, flush,
//  and a multiply-occupancy interlock that holds dependent or back-to-back M-extension ops for MUL_LATENCY cycles.
// PARAMETERS
//  DEPTH        2   output FIFO entries (power of 2, >=2)
//  EN_M         1   1: decode funct7==m_extension op_reg as multiply/divide; 0: flag those as illegal
//  MUL_LATENCY  4   cycles a multiply unit stays busy after an M op leaves the FIFO (1..15)
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous, active-high reset
//  flush        in   1    discard all buffered entries and interlock state
//  in_valid     in   1    in_instr/in_pc valid
//  in_ready     out  1    stage accepts an instruction this cycle
//  in_instr     in   32   raw instruction
//  in_pc        in   32   instruction PC
//  out_valid    out  1    FIFO head valid
//  out_ready    in   1    execute consumes head
//  out_ctrl     out  cw   rv32i_control_word of head
//  out_pc       out  32   PC of head
//  out_rs1/rs2/rd out 5   register indices of head (instr[19:15]/[24:20]/[11:7])
//  out_illegal  out  1    head is an illegal instruction
// BEHAVIOUR
//  Reset: FIFO empty, out_valid=0, in_ready=1, out_illegal=0, out_ctrl/out_pc/out_rs*/out_rd=0, mul counter=0.
//  Decode (comb, on in_instr): defaults opcode=instr[6:0], alu rs1/i_imm op=funct3, cmp rs2/funct3, regfilemux alu_out,
//   mulop=funct3, load_regfile=0, dmem_read/write=0, wmask=0, mulmux true_alu_out.
//   lui->u_imm wb; auipc pc+u_imm wb alu; jal pc+j_imm, jalr rs1+i_imm, both wb pc_plus4; br pc+b_imm, no wb;
//   load rs1+i_imm, dmem_read, wb lb/lh/lw/lbu/lhu; store rs1+s_imm, dmem_write, wmask 0001/0011/1111 for sb/sh/sw;
//   op_imm wb alu_out, slt/sltu -> cmp i_imm blt/bltu wb br_en, sr&funct7[5] -> alu_sra;
//   op_reg alu rs2_out, add&funct7[5] -> alu_sub, slt/sltu cmp rs2_out wb br_en, sr&funct7[5] -> alu_sra;
//   op_reg & funct7==m_extension & EN_M -> mulmux mul_out, wb alu_out.
//  Illegal: opcode outside {lui,auipc,jal,jalr,br,load,store,imm,reg,csr}; load funct3 in {3,6,7}; store funct3>2;
//   M op with EN_M=0. Illegal entries: out_illegal=1, load_regfile=0, dmem_read=0, dmem_write=0, wmask=0.
//   instr==0 is a bubble: accepted, never enqueued.
//  Handshake: enqueue when in_valid&in_ready; dequeue when out_valid&out_ready. Latency 1: instr accepted in cycle N
//   is visible at head in N+1 if FIFO was empty. in_ready = !full | (out_valid&out_ready) (same-cycle enq+deq on full OK).
//   Outputs are registered FIFO head; stable while out_valid&!out_ready.
//  Pointers: log2(DEPTH)-bit rd/wr plus count 0..DEPTH; wrap silently. Full: count==DEPTH. Empty: out_valid=0.
//  Mul interlock: when an M op dequeues, counter loads MUL_LATENCY-1 (or stays 0 if MUL_LATENCY=1); decrements to 0.
//   While counter!=0 the head is held (out_valid=0) if it is an M op or its rs1/rs2 (nonzero) equals busy rd.
//   Held head keeps its data; enqueue continues until full.
//  flush: next cycle FIFO empty, out_valid=0, counter=0; an in_valid in the flush cycle is dropped (in_ready=0).
//  rst overrides flush and any in-flight handshake.
// TESTING
//  1 reset then addi x1,x0,5 (0x00500093) -> next cycle out_valid=1, rd=1, load_regfile=1, regfilemux=alu_out.
//  2 out_ready=0, push DEPTH sw (wmask 1111) -> in_ready=0 after DEPTH; push+pop same cycle while full -> count stays DEPTH.
//  3 mul x3,x1,x2 then add x4,x3,x1 -> add held MUL_LATENCY-1 cycles; add x5,x6,x7 after mul -> no hold.
//  4 EN_M=0 mul -> out_illegal=1, load_regfile=0; opcode 7'b1111111 -> out_illegal=1.
//  5 FIFO full + busy counter, assert flush -> next cycle out_valid=0, in_ready=1, counter=0.
//  6 rst asserted mid-stream with in_valid=1 -> next cycle all outputs at reset values, no entry enqueued.

Source files
------------

// File: rtl/decode_queue_stage.sv
// RV32IM decode stage: combinational decode of the incoming instruction into a control word,
// buffered in a small output FIFO with flush and a multiply-occupancy interlock on the head.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
        alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic {mux1_rs1 = 1'b0, mux1_pc = 1'b1} alumux1_sel_t;

    typedef enum logic [2:0] {
        mux2_i_imm = 3'd0, mux2_u_imm = 3'd1, mux2_b_imm = 3'd2,
        mux2_s_imm = 3'd3, mux2_j_imm = 3'd4, mux2_rs2 = 3'd5
    } alumux2_sel_t;

    typedef enum logic {cmp_mux_rs2 = 1'b0, cmp_mux_i_imm = 1'b1} cmpmux_sel_t;

    typedef enum logic [3:0] {
        rf_alu_out = 4'd0, rf_br_en = 4'd1, rf_u_imm = 4'd2, rf_lw  = 4'd3, rf_pc_plus4 = 4'd4,
        rf_lb      = 4'd5, rf_lbu   = 4'd6, rf_lh    = 4'd7, rf_lhu = 4'd8
    } regfilemux_sel_t;

    typedef enum logic {mul_mux_alu = 1'b0, mul_mux_mul = 1'b1} mulmux_sel_t;

    typedef struct packed {
        rv32i_opcode     opcode;
        alu_ops          aluop;
        branch_funct3_t  cmpop;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        cmpmux_sel_t     cmpmux_sel;
        regfilemux_sel_t regfilemux_sel;
        logic            load_regfile;
        logic            dmem_read;
        logic            dmem_write;
        logic [3:0]      wmask;
        logic [2:0]      mulop;
        mulmux_sel_t     mulmux_sel;
    } rv32i_control_word;

endpackage

module decode_queue_stage
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH       = 2,
    parameter bit          EN_M        = 1'b1,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output rv32i_control_word out_ctrl,
    output logic [31:0]       out_pc,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic              out_illegal
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        rv32i_control_word ctrl;
        logic [31:0]       pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              illegal;
        logic              is_mul;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         mul_cnt_q, mul_cnt_d;
    logic [4:0]         busy_rd_q, busy_rd_d;

    rv32i_control_word  dec_ctrl;
    logic               dec_illegal;
    logic               dec_mul;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    entry_t             head;
    logic               hold, full, enq, deq;

    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        dec_ctrl                = '0;
        dec_ctrl.opcode         = rv32i_opcode'(in_instr[6:0]);
        dec_ctrl.aluop          = alu_ops'(funct3);
        dec_ctrl.cmpop          = branch_funct3_t'(funct3);
        dec_ctrl.alumux1_sel    = mux1_rs1;
        dec_ctrl.alumux2_sel    = mux2_i_imm;
        dec_ctrl.cmpmux_sel     = cmp_mux_rs2;
        dec_ctrl.regfilemux_sel = rf_alu_out;
        dec_ctrl.mulop          = funct3;
        dec_ctrl.mulmux_sel     = mul_mux_alu;
        dec_illegal             = 1'b0;
        dec_mul                 = 1'b0;
        case (in_instr[6:0])
            op_lui: begin
                dec_ctrl.load_regfile   = 1'b1;
                dec_ctrl.regfilemux_sel = rf_u_imm;
            end
            op_auipc: begin
                dec_ctrl.alumux1_sel  = mux1_pc;
                dec_ctrl.alumux2_sel  = mux2_u_imm;
                dec_ctrl.aluop        = alu_add;
                dec_ctrl.load_regfile = 1'b1;
            end
            op_jal: begin
                dec_ctrl.alumux1_sel    = mux1_pc;
                dec_ctrl.alumux2_sel    = mux2_j_imm;
                dec_ctrl.aluop          = alu_add;
                dec_ctrl.load_regfile   = 1'b1;
                dec_ctrl.regfilemux_sel = rf_pc_plus4;
            end
            op_jalr: begin
                dec_ctrl.aluop          = alu_add;
                dec_ctrl.load_regfile   = 1'b1;
                dec_ctrl.regfilemux_sel = rf_pc_plus4;
            end
            op_br: begin
                dec_ctrl.alumux1_sel = mux1_pc;
                dec_ctrl.alumux2_sel = mux2_b_imm;
                dec_ctrl.aluop       = alu_add;
            end
            op_load: begin
                dec_ctrl.aluop        = alu_add;
                dec_ctrl.dmem_read    = 1'b1;
                dec_ctrl.load_regfile = 1'b1;
                case (funct3)
                    3'd0:    dec_ctrl.regfilemux_sel = rf_lb;
                    3'd1:    dec_ctrl.regfilemux_sel = rf_lh;
                    3'd2:    dec_ctrl.regfilemux_sel = rf_lw;
                    3'd4:    dec_ctrl.regfilemux_sel = rf_lbu;
                    3'd5:    dec_ctrl.regfilemux_sel = rf_lhu;
                    default: dec_illegal = 1'b1;
                endcase
            end
            op_store: begin
                dec_ctrl.alumux2_sel = mux2_s_imm;
                dec_ctrl.aluop       = alu_add;
                dec_ctrl.dmem_write  = 1'b1;
                case (funct3)
                    3'd0:    dec_ctrl.wmask = 4'b0001;
                    3'd1:    dec_ctrl.wmask = 4'b0011;
                    3'd2:    dec_ctrl.wmask = 4'b1111;
                    default: dec_illegal = 1'b1;
                endcase
            end
            op_imm: begin
                dec_ctrl.load_regfile = 1'b1;
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    dec_ctrl.cmpop          = (funct3 == 3'd2) ? blt : bltu;
                    dec_ctrl.cmpmux_sel     = cmp_mux_i_imm;
                    dec_ctrl.regfilemux_sel = rf_br_en;
                end else if (funct3 == 3'd5 && funct7[5]) begin
                    dec_ctrl.aluop = alu_sra;
                end
            end
            op_reg: begin
                dec_ctrl.alumux2_sel  = mux2_rs2;
                dec_ctrl.load_regfile = 1'b1;
                if (funct7 == 7'b0000001) begin
                    if (EN_M) begin
                        dec_ctrl.mulmux_sel = mul_mux_mul;
                        dec_mul             = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else if (funct3 == 3'd0 && funct7[5]) begin
                    dec_ctrl.aluop = alu_sub;
                end else if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    dec_ctrl.cmpop          = (funct3 == 3'd2) ? blt : bltu;
                    dec_ctrl.regfilemux_sel = rf_br_en;
                end else if (funct3 == 3'd5 && funct7[5]) begin
                    dec_ctrl.aluop = alu_sra;
                end
            end
            op_csr: ;
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctrl.load_regfile = 1'b0;
            dec_ctrl.dmem_read    = 1'b0;
            dec_ctrl.dmem_write   = 1'b0;
            dec_ctrl.wmask        = '0;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign full = (count_q == CNT_W'(DEPTH));

    // Head waits while a multiply is busy if it needs the unit or reads the busy destination.
    assign hold = (mul_cnt_q != '0) &&
                  (head.is_mul ||
                   (head.rs1 != '0 && head.rs1 == busy_rd_q) ||
                   (head.rs2 != '0 && head.rs2 == busy_rd_q));

    assign out_valid   = (count_q != '0) && !hold;
    assign in_ready    = !flush && (!full || (out_valid && out_ready));
    assign enq         = in_valid && in_ready && (in_instr != '0);
    assign deq         = out_valid && out_ready && !flush;

    assign out_ctrl    = head.ctrl;
    assign out_pc      = head.pc;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_illegal = head.illegal;

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        mul_cnt_d = mul_cnt_q;
        busy_rd_d = busy_rd_q;
        if (enq) begin
            mem_d[wr_ptr_q].ctrl    = dec_ctrl;
            mem_d[wr_ptr_q].pc      = in_pc;
            mem_d[wr_ptr_q].rs1     = in_instr[19:15];
            mem_d[wr_ptr_q].rs2     = in_instr[24:20];
            mem_d[wr_ptr_q].rd      = in_instr[11:7];
            mem_d[wr_ptr_q].illegal = dec_illegal;
            mem_d[wr_ptr_q].is_mul  = dec_mul;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (deq && !enq) begin
            count_d = count_q - 1'b1;
        end
        if (deq && head.is_mul) begin
            mul_cnt_d = 4'(MUL_LATENCY - 1);
            busy_rd_d = head.rd;
        end else if (mul_cnt_q != '0) begin
            mul_cnt_d = mul_cnt_q - 1'b1;
        end
        if (flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            mul_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q     <= '{default: '0};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            mul_cnt_q <= '0;
            busy_rd_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            mul_cnt_q <= mul_cnt_d;
            busy_rd_q <= busy_rd_d;
        end
    end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage: an EN_M=1 and an EN_M=0 instance share one stimulus stream.
module tb_decode_queue_stage;
    import rv32i_types::*;

    localparam int unsigned DEPTH       = 2;
    localparam int unsigned MUL_LATENCY = 4;

    localparam logic [31:0] I_ADDI   = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_SW0    = 32'h0020_A023; // sw x2,0(x1)
    localparam logic [31:0] I_SW4    = 32'h0030_A223; // sw x3,4(x1)
    localparam logic [31:0] I_MUL    = 32'h0220_81B3; // mul x3,x1,x2
    localparam logic [31:0] I_ADD_D  = 32'h0011_8233; // add x4,x3,x1
    localparam logic [31:0] I_ADD_I  = 32'h0073_02B3; // add x5,x6,x7
    localparam logic [31:0] I_BADOP  = 32'h0000_007F;

    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic              in_ready, out_valid, out_illegal;
    rv32i_control_word out_ctrl;
    logic [31:0]       out_pc;
    logic [4:0]        out_rs1, out_rs2, out_rd;

    logic              nm_in_ready, nm_out_valid, nm_out_illegal;
    rv32i_control_word nm_out_ctrl;
    logic [31:0]       nm_out_pc;
    logic [4:0]        nm_out_rs1, nm_out_rs2, nm_out_rd;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned held;

    always #5 clk = ~clk;

    decode_queue_stage #(.DEPTH(DEPTH), .EN_M(1'b1), .MUL_LATENCY(MUL_LATENCY)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    decode_queue_stage #(.DEPTH(DEPTH), .EN_M(1'b0), .MUL_LATENCY(MUL_LATENCY)) dut_nm (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(nm_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(nm_out_valid), .out_ready(out_ready), .out_ctrl(nm_out_ctrl), .out_pc(nm_out_pc),
        .out_rs1(nm_out_rs1), .out_rs2(nm_out_rs2), .out_rd(nm_out_rd), .out_illegal(nm_out_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        tick();
        tick();
        rst = 1'b0;
        settle();

        // reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);

        // addi visible one cycle after acceptance
        push(I_ADDI, 32'h100);
        settle();
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_load_rf", 64'(out_ctrl.load_regfile), 64'd1);
        chk("addi_rfmux", 64'(out_ctrl.regfilemux_sel), 64'(rf_alu_out));
        chk("addi_mux2", 64'(out_ctrl.alumux2_sel), 64'(mux2_i_imm));
        chk("addi_pc", 64'(out_pc), 64'h100);
        chk("addi_nm_legal", 64'(nm_out_illegal), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("addi_drained", 64'(out_valid), 64'd0);

        // fill with stores, then enqueue+dequeue while full
        out_ready = 1'b0;
        push(I_SW0, 32'h200);
        settle();
        chk("fill1_in_ready", 64'(in_ready), 64'd1);
        push(I_SW4, 32'h204);
        settle();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("sw_wmask", 64'(out_ctrl.wmask), 64'hF);
        chk("sw_dmem_write", 64'(out_ctrl.dmem_write), 64'd1);
        chk("sw_load_rf", 64'(out_ctrl.load_regfile), 64'd0);
        chk("sw_pc", 64'(out_pc), 64'h200);
        chk("sw_rs2", 64'(out_rs2), 64'd2);
        in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h208; out_ready = 1'b1;
        settle();
        chk("full_pushpop_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        settle();
        chk("still_full", 64'(in_ready), 64'd0);
        chk("head_after_pushpop", 64'(out_pc), 64'h204);
        chk("head_rs2_after_pushpop", 64'(out_rs2), 64'd3);
        out_ready = 1'b1;
        tick();
        chk("wrap_head_pc", 64'(out_pc), 64'h208);
        chk("wrap_head_rd", 64'(out_rd), 64'd1);
        tick();
        chk("drained2", 64'(out_valid), 64'd0);

        // dependent op after a multiply is held MUL_LATENCY-1 cycles
        out_ready = 1'b0;
        push(I_MUL, 32'h300);
        push(I_ADD_D, 32'h304);
        settle();
        chk("mul_valid", 64'(out_valid), 64'd1);
        chk("mul_mulmux", 64'(out_ctrl.mulmux_sel), 64'(mul_mux_mul));
        chk("mul_rfmux", 64'(out_ctrl.regfilemux_sel), 64'(rf_alu_out));
        chk("mul_rd", 64'(out_rd), 64'd3);
        chk("nm_mul_illegal", 64'(nm_out_illegal), 64'd1);
        chk("nm_mul_load_rf", 64'(nm_out_ctrl.load_regfile), 64'd0);
        chk("nm_mul_mulmux", 64'(nm_out_ctrl.mulmux_sel), 64'(mul_mux_alu));
        out_ready = 1'b1;
        tick();
        chk("held_head_pc", 64'(out_pc), 64'h304);
        held = 0;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            held++;
            tick();
        end
        chk("dep_hold_cycles", 64'(held), 64'(MUL_LATENCY - 1));
        chk("dep_release_pc", 64'(out_pc), 64'h304);
        tick();
        chk("drained3", 64'(out_valid), 64'd0);

        // independent op after a multiply is not held
        out_ready = 1'b0;
        push(I_MUL, 32'h310);
        push(I_ADD_I, 32'h314);
        out_ready = 1'b1;
        tick();
        chk("indep_valid", 64'(out_valid), 64'd1);
        chk("indep_pc", 64'(out_pc), 64'h314);
        tick();

        // undefined opcode flagged illegal in both configurations
        out_ready = 1'b0;
        push(I_BADOP, 32'h320);
        settle();
        chk("badop_valid", 64'(out_valid), 64'd1);
        chk("badop_illegal", 64'(out_illegal), 64'd1);
        chk("badop_load_rf", 64'(out_ctrl.load_regfile), 64'd0);
        chk("badop_opcode", 64'(out_ctrl.opcode), 64'h7F);
        chk("nm_badop_illegal", 64'(nm_out_illegal), 64'd1);
        out_ready = 1'b1;
        tick();

        // all-zero instruction is accepted but never enqueued
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = '0; in_pc = 32'h330;
        settle();
        chk("bubble_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        settle();
        chk("bubble_not_queued", 64'(out_valid), 64'd0);

        // flush with a full FIFO and a busy multiply counter
        push(I_MUL, 32'h400);
        push(I_ADD_D, 32'h404);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = I_ADD_D; in_pc = 32'h408;
        tick();
        in_valid = 1'b0;
        settle();
        chk("busy_full_valid", 64'(out_valid), 64'd0);
        chk("busy_full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h40C;
        settle();
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        chk("post_flush_valid", 64'(out_valid), 64'd0);
        chk("post_flush_ready", 64'(in_ready), 64'd1);
        push(I_ADD_D, 32'h410);
        settle();
        chk("post_flush_no_hold", 64'(out_valid), 64'd1);
        chk("post_flush_pc", 64'(out_pc), 64'h410);
        tick();

        // reset mid-stream with a pending input
        out_ready = 1'b0;
        push(I_ADDI, 32'h500);
        rst = 1'b1;
        in_valid = 1'b1; in_instr = I_SW0; in_pc = 32'h504;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        settle();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_illegal", 64'(out_illegal), 64'd0);
        chk("midrst_ctrl", 64'(out_ctrl), 64'd0);
        chk("midrst_pc", 64'(out_pc), 64'd0);
        chk("midrst_rs1", 64'(out_rs1), 64'd0);
        chk("midrst_rd", 64'(out_rd), 64'd0);
        tick();
        chk("midrst_nothing_queued", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
